// File: rtl/gru_act_scheduler_if.sv
// Signal bundle between the GRU gate requesters, the scheduler and the shared
// activation unit.
//
// Handshake: requester i transfers one operation (req_x slice i, req_func[i])
// in any cycle where req_valid[i] & req_ready[i] is 1. The scheduler never
// raises req_ready[i] while req_valid[i] is 0, and at most one req_ready bit is
// high per cycle. act_valid and resp_valid are single-cycle strobes with no
// backpressure; resp_y/resp_id are meaningful only while resp_valid is set.
interface gru_act_scheduler_if #(
  parameter int NUM_REQ  = 3,
  parameter int WIDTH    = 17,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_func;
  logic [NUM_REQ*WIDTH-1:0] req_x;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     act_valid;
  logic                     act_func;
  logic [WIDTH-1:0]         act_x;
  logic [WIDTH-1:0]         act_y;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]         resp_y;
  logic [ID_WIDTH-1:0]      resp_id;

  // Requesters plus activation unit side.
  modport master (
    output req_valid, req_func, req_x, act_y,
    input  req_ready, act_valid, act_func, act_x, resp_valid, resp_y, resp_id
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_func, req_x, act_y,
    output req_ready, act_valid, act_func, act_x, resp_valid, resp_y, resp_id
  );
endinterface

// File: rtl/gru_act_scheduler.sv
// Round-robin scheduler sharing one sigmoid/tanh unit among NUM_REQ GRU gate
// requesters. One operation is issued per cycle; a {valid, id} tag travels
// alongside the fixed-latency unit so each result returns to its requester,
// in grant order.
module gru_act_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int INT_WIDTH   = 8,
  parameter int FRAC_WIDTH  = 8,
  parameter int WIDTH       = INT_WIDTH + FRAC_WIDTH + 1,
  parameter int ACT_LATENCY = 0,
  parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sched_en,
  gru_act_scheduler_if.slave bus,
  output logic               busy
);

  localparam int unsigned         IDX_W       = ID_WIDTH + 1;
  localparam logic [IDX_W-1:0]    NUM_REQ_IDX = IDX_W'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID     = ID_WIDTH'(NUM_REQ - 1);

  // Arbitration
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [IDX_W-1:0]    scan_idx;
  logic                grant_any;
  logic [ID_WIDTH-1:0] grant_id;
  logic [ID_WIDTH-1:0] ptr_next;
  logic [NUM_REQ-1:0]  grant;

  // Issue stage
  logic                act_valid_q;
  logic                act_func_q;
  logic [WIDTH-1:0]    act_x_q;
  logic [ID_WIDTH-1:0] issue_id;

  // Tag pipeline output
  logic                tag_out_valid;
  logic [ID_WIDTH-1:0] tag_out_id;
  logic                tag_busy;

  // Response stage
  logic [NUM_REQ-1:0]  resp_valid_q;
  logic [WIDTH-1:0]    resp_y_q;
  logic [ID_WIDTH-1:0] resp_id_q;

  // Round-robin search from rr_ptr; scanning from the farthest slot back to
  // rr_ptr and overwriting leaves the nearest valid requester as the winner.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    if (reset && sched_en) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        scan_idx = {1'b0, rr_ptr} + IDX_W'(k);
        if (scan_idx >= NUM_REQ_IDX) begin
          scan_idx = scan_idx - NUM_REQ_IDX;
        end
        if (bus.req_valid[scan_idx[ID_WIDTH-1:0]]) begin
          grant_any = 1'b1;
          grant_id  = scan_idx[ID_WIDTH-1:0];
        end
      end
    end
  end

  // One-hot grant vector; zero whenever nothing is granted.
  always_comb begin
    grant = '0;
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end
  end

  // Pointer moves just past the winner so it gets lowest priority next time.
  assign ptr_next = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  // Issue register: latch the winner's operand and tag; hold data when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      act_valid_q <= 1'b0;
      act_func_q  <= 1'b0;
      act_x_q     <= '0;
      issue_id    <= '0;
    end else begin
      act_valid_q <= grant_any;
      if (grant_any) begin
        rr_ptr     <= ptr_next;
        act_func_q <= bus.req_func[grant_id];
        act_x_q    <= bus.req_x[grant_id*WIDTH +: WIDTH];
        issue_id   <= grant_id;
      end
    end
  end

  generate
    if (ACT_LATENCY == 0) begin : g_no_pipe
      // Combinational unit: the issue tag lines up with act_y directly.
      assign tag_out_valid = act_valid_q;
      assign tag_out_id    = issue_id;
      assign tag_busy      = 1'b0;
    end else begin : g_pipe
      logic [ACT_LATENCY-1:0]               tag_v;
      logic [ACT_LATENCY-1:0][ID_WIDTH-1:0] tag_id;

      // Tags advance one stage every cycle, matching the unit's fixed latency.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tag_v  <= '0;
          tag_id <= '0;
        end else begin
          tag_v[0]  <= act_valid_q;
          tag_id[0] <= issue_id;
          for (int s = 1; s < ACT_LATENCY; s++) begin
            tag_v[s]  <= tag_v[s-1];
            tag_id[s] <= tag_id[s-1];
          end
        end
      end

      assign tag_out_valid = tag_v[ACT_LATENCY-1];
      assign tag_out_id    = tag_id[ACT_LATENCY-1];
      assign tag_busy      = |tag_v;
    end
  endgenerate

  // Response register: capture act_y with its tag and strobe the owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= '0;
      resp_y_q     <= '0;
      resp_id_q    <= '0;
    end else begin
      resp_valid_q <= '0;
      if (tag_out_valid) begin
        resp_valid_q[tag_out_id] <= 1'b1;
        resp_y_q                 <= bus.act_y;
        resp_id_q                <= tag_out_id;
      end
    end
  end

  // Busy covers issue, every tag stage and the cycle the response is shown.
  assign busy = act_valid_q | tag_busy | (|resp_valid_q);

  assign bus.req_ready  = grant;
  assign bus.act_valid  = act_valid_q;
  assign bus.act_func   = act_func_q;
  assign bus.act_x      = act_x_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_y     = resp_y_q;
  assign bus.resp_id    = resp_id_q;

endmodule

// File: tb/tb_gru_act_scheduler.sv
// Bench for gru_act_scheduler: two instances (unit latency 0 and 3) receive
// identical requester stimulus. A reference model built from the round-robin
// and fixed-latency rules predicts grants, responses and busy each cycle.
module tb_gru_act_scheduler;
  localparam int N   = 3;
  localparam int W   = 17;
  localparam int IDW = 2;
  localparam int OW  = 2*N + IDW + W + 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           sched_en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_func = '0;
  logic [N*W-1:0] req_x = '0;
  logic           busy0;
  logic           busy3;
  int             n_checks = 0;
  int             n_errors = 0;
  int             cyc = 0;
  int             lat [2] = '{0, 3};

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gru_act_scheduler_if #(.NUM_REQ(N), .WIDTH(W), .ID_WIDTH(IDW)) if0 ();
  gru_act_scheduler_if #(.NUM_REQ(N), .WIDTH(W), .ID_WIDTH(IDW)) if3 ();

  assign if0.req_valid = req_valid;
  assign if0.req_func  = req_func;
  assign if0.req_x     = req_x;
  assign if3.req_valid = req_valid;
  assign if3.req_func  = req_func;
  assign if3.req_x     = req_x;

  // Activation unit stand-in: negate for tanh, pass for sigmoid.
  assign if0.act_y = if0.act_func ? -if0.act_x : if0.act_x;
  logic [W-1:0] ypipe [3];
  always @(posedge clk) begin
    ypipe[0] <= if3.act_func ? -if3.act_x : if3.act_x;
    ypipe[1] <= ypipe[0];
    ypipe[2] <= ypipe[1];
  end
  assign if3.act_y = ypipe[2];

  gru_act_scheduler #(.NUM_REQ(N), .INT_WIDTH(8), .FRAC_WIDTH(8), .ACT_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .sched_en(sched_en), .bus(if0), .busy(busy0)
  );
  gru_act_scheduler #(.NUM_REQ(N), .INT_WIDTH(8), .FRAC_WIDTH(8), .ACT_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .sched_en(sched_en), .bus(if3), .busy(busy3)
  );

  // Observed outputs; response data only counts while resp_valid is set.
  logic [OW-1:0] obs [2];
  assign obs[0] = {if0.req_ready, if0.resp_valid,
                   (|if0.resp_valid) ? if0.resp_id : {IDW{1'b0}},
                   (|if0.resp_valid) ? if0.resp_y : {W{1'b0}}, busy0};
  assign obs[1] = {if3.req_ready, if3.resp_valid,
                   (|if3.resp_valid) ? if3.resp_id : {IDW{1'b0}},
                   (|if3.resp_valid) ? if3.resp_y : {W{1'b0}}, busy3};

  // Reference model: granted operations wait in exp_q with their grant cycle.
  typedef struct {
    int           tg;
    int           id;
    logic [W-1:0] y;
  } op_t;
  op_t           exp_q [$];
  int            rr_ptr_m = 0;
  logic [OW-1:0] exp_v [2];

  always @(negedge clk) begin
    int           g;
    logic [N-1:0] rdy;
    logic [N-1:0] rv;
    logic [IDW-1:0] rid;
    logic [W-1:0] ry;
    logic [W-1:0] xi;
    logic [W-1:0] yv;
    logic         bz;
    if (!reset) begin
      exp_q.delete();
      rr_ptr_m = 0;
      exp_v[0] = '0;
      exp_v[1] = '0;
    end else begin
      g = -1;
      if (sched_en) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(rr_ptr_m + k) % N]) g = (rr_ptr_m + k) % N;
        end
      end
      rdy = '0;
      xi = '0;
      yv = '0;
      if (g >= 0) begin
        rdy[g] = 1'b1;
        xi = req_x[g*W +: W];
        yv = req_func[g] ? -xi : xi;
      end
      for (int j = 0; j < 2; j++) begin
        rv = '0;
        rid = '0;
        ry = '0;
        bz = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
          if (exp_q[k].tg < cyc && cyc <= exp_q[k].tg + 2 + lat[j]) bz = 1'b1;
          if (exp_q[k].tg + 2 + lat[j] == cyc) begin
            rv[exp_q[k].id] = 1'b1;
            rid = IDW'(exp_q[k].id);
            ry = exp_q[k].y;
          end
        end
        exp_v[j] = {rdy, rv, rid, ry, bz};
      end
      while (exp_q.size() > 0 && exp_q[0].tg + 5 <= cyc) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back('{tg: cyc, id: g, y: yv});
        rr_ptr_m = (g + 1) % N;
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] f,
                       input logic [N*W-1:0] x, input logic en);
    req_valid = v;
    req_func  = f;
    req_x     = x;
    sched_en  = en;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive('0, '0, '0, 1'b1);
    next_cycle();
    reset = 1'b1;
  endtask

  function automatic logic [N*W-1:0] rand_x();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    drive('1, '1, rand_x(), 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if ({obs[0], obs[1], if0.act_valid, if0.act_func, if0.act_x,
           if3.act_valid, if3.act_func, if3.act_x} !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs: got %h / %h act0=%b%b%h act3=%b%b%h expected all zero",
                 obs[0], obs[1], if0.act_valid, if0.act_func, if0.act_x,
                 if3.act_valid, if3.act_func, if3.act_x);
      end
      next_cycle();
    end
    drive('0, '0, '0, 1'b1);
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [N*W-1:0] x;
    logic [N-1:0]   f;
    x = rand_x();
    x[W-1:0] = 17'h00100;
    f = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0};
    for (int k = 0; k < 5; k++) begin
      drive((k == 0) ? 3'b001 : 3'b000, f, x, 1'b1);
      @(negedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (obs[j] !== exp_v[j]) begin
          n_errors++;
          $display("FAIL single lat%0d cyc%0d: got %h expected %h", lat[j], cyc, obs[j], exp_v[j]);
        end
      end
      if (k == 0) begin
        n_checks++;
        if (if0.req_ready !== 3'b001) begin
          n_errors++;
          $display("FAIL single_grant: got %b expected 001", if0.req_ready);
        end
      end
      if (k == 1) begin
        n_checks++;
        if ({if0.act_valid, if0.act_func, if0.act_x} !== {2'b10, 17'h00100}) begin
          n_errors++;
          $display("FAIL single_issue: got %b %b %h expected 1 0 00100",
                   if0.act_valid, if0.act_func, if0.act_x);
        end
      end
      if (k == 2) begin
        n_checks++;
        if ({if0.resp_valid, if0.resp_id, if0.resp_y} !== {3'b001, 2'd0, 17'h00100}) begin
          n_errors++;
          $display("FAIL single_resp: got %b %0d %h expected 001 0 00100",
                   if0.resp_valid, if0.resp_id, if0.resp_y);
        end
      end
      if (k == 3) begin
        n_checks++;
        if (busy0 !== 1'b0) begin
          n_errors++;
          $display("FAIL single_busy_fall: got %b expected 0", busy0);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] x;
    x = {17'd3, 17'd2, 17'd1};
    apply_reset();
    for (int k = 0; k < 14; k++) begin
      drive((k < 6) ? 3'b111 : 3'b000, 3'b000, x, 1'b1);
      @(negedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (obs[j] !== exp_v[j]) begin
          n_errors++;
          $display("FAIL back_to_back lat%0d cyc%0d: got %h expected %h", lat[j], cyc, obs[j], exp_v[j]);
        end
      end
      if (k < 6) begin
        n_checks++;
        if (if0.req_ready !== (3'b001 << (k % 3))) begin
          n_errors++;
          $display("FAIL b2b_grant k%0d: got %b expected %b", k, if0.req_ready, 3'b001 << (k % 3));
        end
      end
      if (k >= 2 && k < 8) begin
        n_checks++;
        if (if0.resp_valid !== (3'b001 << ((k - 2) % 3)) || if0.resp_id !== IDW'((k - 2) % 3)) begin
          n_errors++;
          $display("FAIL b2b_resp k%0d: got %b id %0d expected id %0d", k, if0.resp_valid,
                   if0.resp_id, (k - 2) % 3);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_negate();
    logic [N*W-1:0] x;
    logic [N-1:0]   f;
    apply_reset();
    x = rand_x();
    x[2*W +: W] = 17'h00200;
    f = {1'b1, 1'($urandom_range(0, 1)), 1'b0};
    for (int k = 0; k < 8; k++) begin
      drive((k == 0) ? 3'b110 : (k == 1) ? 3'b100 : 3'b000, f, x, 1'b1);
      @(negedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (obs[j] !== exp_v[j]) begin
          n_errors++;
          $display("FAIL negate lat%0d cyc%0d: got %h expected %h", lat[j], cyc, obs[j], exp_v[j]);
        end
      end
      if (k < 2) begin
        n_checks++;
        if (if0.req_ready !== ((k == 0) ? 3'b010 : 3'b100)) begin
          n_errors++;
          $display("FAIL negate_grant k%0d: got %b", k, if0.req_ready);
        end
      end
      if (k == 3) begin
        n_checks++;
        if ({if0.resp_valid, if0.resp_id, if0.resp_y} !== {3'b100, 2'd2, 17'h1FE00}) begin
          n_errors++;
          $display("FAIL negate_resp: got %b %0d %h expected 100 2 1fe00",
                   if0.resp_valid, if0.resp_id, if0.resp_y);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_latency3();
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      drive((k < 2) ? 3'b001 : 3'b000, 3'($urandom), rand_x(), 1'b1);
      @(negedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (obs[j] !== exp_v[j]) begin
          n_errors++;
          $display("FAIL latency3 lat%0d cyc%0d: got %h expected %h", lat[j], cyc, obs[j], exp_v[j]);
        end
      end
      n_checks++;
      if ((|if3.resp_valid) !== (k == 5 || k == 6) || busy3 !== (k >= 1 && k <= 6)) begin
        n_errors++;
        $display("FAIL latency3_timing k%0d: got resp %b busy %b expected resp %b busy %b",
                 k, |if3.resp_valid, busy3, (k == 5 || k == 6), (k >= 1 && k <= 6));
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      drive((k == 0) ? 3'b001 : 3'b010, 3'($urandom), rand_x(), 1'b1);
      @(negedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (obs[j] !== exp_v[j]) begin
          n_errors++;
          $display("FAIL inflight lat%0d cyc%0d: got %h expected %h", lat[j], cyc, obs[j], exp_v[j]);
        end
      end
      next_cycle();
    end
    reset = 1'b0;
    drive('0, '0, '0, 1'b1);
    #1;
    n_checks++;
    if ({obs[0], obs[1], if0.act_valid, if0.act_x, if3.act_valid, if3.act_x} !== '0) begin
      n_errors++;
      $display("FAIL inflight_reset_now: got %h / %h act %b %h / %b %h expected all zero",
               obs[0], obs[1], if0.act_valid, if0.act_x, if3.act_valid, if3.act_x);
    end
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive((k == 8) ? 3'b111 : 3'b000, 3'($urandom), rand_x(), 1'b1);
      @(negedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (obs[j] !== exp_v[j]) begin
          n_errors++;
          $display("FAIL after_reset lat%0d cyc%0d: got %h expected %h", lat[j], cyc, obs[j], exp_v[j]);
        end
      end
      if (k < 8) begin
        n_checks++;
        if ((|if0.resp_valid) || (|if3.resp_valid)) begin
          n_errors++;
          $display("FAIL stale_resp k%0d: got %b %b expected 000 000", k, if0.resp_valid, if3.resp_valid);
        end
      end
      if (k == 8) begin
        n_checks++;
        if (if3.req_ready !== 3'b001) begin
          n_errors++;
          $display("FAIL post_reset_grant: got %b expected 001", if3.req_ready);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_sched_en();
    apply_reset();
    for (int k = 0; k < 14; k++) begin
      if (k == 0) drive(3'b001, 3'($urandom), rand_x(), 1'b1);
      else if (k < 7) drive(3'b111, 3'($urandom), rand_x(), 1'b0);
      else if (k == 7) drive(3'b111, 3'($urandom), rand_x(), 1'b1);
      else drive(3'b000, 3'b000, rand_x(), 1'b1);
      @(negedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (obs[j] !== exp_v[j]) begin
          n_errors++;
          $display("FAIL sched_en lat%0d cyc%0d: got %h expected %h", lat[j], cyc, obs[j], exp_v[j]);
        end
      end
      if (k >= 1 && k < 7) begin
        n_checks++;
        if (if0.req_ready !== 3'b000 || if3.req_ready !== 3'b000) begin
          n_errors++;
          $display("FAIL sched_off_grant k%0d: got %b %b expected 000", k, if0.req_ready, if3.req_ready);
        end
      end
      if (k == 6) begin
        n_checks++;
        if (busy0 !== 1'b0 || busy3 !== 1'b0) begin
          n_errors++;
          $display("FAIL sched_off_drain: got busy %b %b expected 0 0", busy0, busy3);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (if0.req_ready !== 3'b010) begin
          n_errors++;
          $display("FAIL sched_resume_grant: got %b expected 010", if0.req_ready);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if (k < 390) drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rand_x(),
                         ($urandom_range(0, 9) != 0));
      else drive(3'b000, 3'b000, rand_x(), 1'b1);
      @(negedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (obs[j] !== exp_v[j]) begin
          n_errors++;
          $display("FAIL random lat%0d cyc%0d: got %h expected %h", lat[j], cyc, obs[j], exp_v[j]);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_negate();
    test_latency3();
    test_reset_inflight();
    test_sched_en();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
